fsm: RTL and testbench

- Trace-connector state machine between the CVA6 commit stage and the RISC-V E-trace encoder.
- Consumes one committed micro-op entry (uop_entry_s, from mure_pkg) per cycle.
- Groups consecutive retired instructions into blocks and emits one E-trace block record per block: instruction count, block start address, type, cause, tval, privilege.
- A block closes on a discontinuity (trap, return, branch, jump) or on counter saturation.

---
 rtl/mure_pkg.sv | 19 +
 rtl/fsm.sv | 180 ++++++++++++++++++
 tb/tb_fsm.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// Shared widths and the committed-uop record handed from the commit stage to the trace connector.
package mure_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned CAUSE_LEN = 5;
  localparam int unsigned PRIV_LEN  = 2;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [ITYPE_LEN-1:0] itype;
    logic                 compressed;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } uop_entry_s;

endpackage

// File: rtl/fsm.sv
// Trace connector: groups retired uops into E-trace blocks and emits one registered record per block.
module fsm
  import mure_pkg::*;
#(
  parameter int unsigned IRETIRE_LEN = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  uop_entry_s           uop_entry_i,
  output logic                 valid_o,
  output logic [IRETIRE_LEN-1:0] iretire_o,
  output logic                 ilastsize_o,
  output logic [ITYPE_LEN-1:0] itype_o,
  output logic [CAUSE_LEN-1:0] cause_o,
  output logic [XLEN-1:0]      tval_o,
  output logic [PRIV_LEN-1:0]  priv_o,
  output logic [XLEN-1:0]      iaddr_o
);

  typedef logic [IRETIRE_LEN-1:0] cnt_t;

  typedef struct packed {
    cnt_t                 iretire;
    logic                 ilastsize;
    logic [ITYPE_LEN-1:0] itype;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
    logic [XLEN-1:0]      iaddr;
  } rec_t;

  typedef enum logic {IDLE, COUNT} state_e;

  localparam logic [ITYPE_LEN-1:0] IT_STD = ITYPE_LEN'(0);
  localparam logic [ITYPE_LEN-1:0] IT_EXC = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0] IT_INT = ITYPE_LEN'(2);
  localparam logic [ITYPE_LEN-1:0] IT_RSV = ITYPE_LEN'(7);

  function automatic logic [ITYPE_LEN-1:0] norm_type(logic [ITYPE_LEN-1:0] t);
    return (t == IT_RSV) ? IT_STD : t;
  endfunction

  function automatic logic is_trap(logic [ITYPE_LEN-1:0] t);
    return (t == IT_EXC) || (t == IT_INT);
  endfunction

  function automatic cnt_t uop_size(logic compressed);
    return compressed ? cnt_t'(1) : cnt_t'(2);
  endfunction

  // Record for a uop seen with no open block: traps carry no instructions.
  function automatic rec_t idle_rec(uop_entry_s u);
    rec_t r;
    r       = '0;
    r.itype = norm_type(u.itype);
    r.priv  = u.priv;
    r.iaddr = u.pc;
    if (is_trap(r.itype)) begin
      r.cause = u.cause;
      r.tval  = u.tval;
    end else begin
      r.iretire   = uop_size(u.compressed);
      r.ilastsize = ~u.compressed;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [XLEN-1:0]  start_q, start_d;
  cnt_t             count_q, count_d;
  logic             last_q, last_d;
  uop_entry_s       held_q, held_d;
  rec_t             rec_q, rec_d;
  logic             valid_q, valid_d;

  logic [ITYPE_LEN-1:0] in_type;
  cnt_t                 in_size;
  logic [IRETIRE_LEN:0] sum;

  assign in_type = norm_type(uop_entry_i.itype);
  assign in_size = uop_size(uop_entry_i.compressed);
  assign sum     = {1'b0, count_q} + {1'b0, in_size};

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    count_d = count_q;
    last_d  = last_q;
    held_d  = held_q;
    rec_d   = rec_q;
    valid_d = 1'b0;
    if (held_q.valid) begin
      // A closing uop deferred by saturation owns this cycle's emission slot;
      // a closing uop arriving now takes its place in the hold register.
      valid_d = 1'b1;
      rec_d   = idle_rec(held_q);
      held_d  = '0;
      if (uop_entry_i.valid) begin
        if (in_type == IT_STD) begin
          state_d = COUNT;
          start_d = uop_entry_i.pc;
          count_d = in_size;
          last_d  = ~uop_entry_i.compressed;
        end else begin
          held_d = uop_entry_i;
        end
      end
    end else if (uop_entry_i.valid) begin
      if (state_q == IDLE) begin
        if (in_type == IT_STD) begin
          state_d = COUNT;
          start_d = uop_entry_i.pc;
          count_d = in_size;
          last_d  = ~uop_entry_i.compressed;
        end else begin
          valid_d = 1'b1;
          rec_d   = idle_rec(uop_entry_i);
        end
      end else if (is_trap(in_type)) begin
        valid_d = 1'b1;
        rec_d   = '{iretire: count_q, ilastsize: last_q, itype: in_type,
                    cause: uop_entry_i.cause, tval: uop_entry_i.tval,
                    priv: uop_entry_i.priv, iaddr: start_q};
        state_d = IDLE;
      end else if (sum[IRETIRE_LEN]) begin
        valid_d = 1'b1;
        rec_d   = '{iretire: count_q, ilastsize: last_q, itype: IT_STD,
                    cause: '0, tval: '0, priv: uop_entry_i.priv, iaddr: start_q};
        if (in_type == IT_STD) begin
          start_d = uop_entry_i.pc;
          count_d = in_size;
          last_d  = ~uop_entry_i.compressed;
        end else begin
          held_d  = uop_entry_i;
          state_d = IDLE;
        end
      end else begin
        count_d = sum[IRETIRE_LEN-1:0];
        last_d  = ~uop_entry_i.compressed;
        if (in_type != IT_STD) begin
          valid_d = 1'b1;
          rec_d   = '{iretire: sum[IRETIRE_LEN-1:0], ilastsize: ~uop_entry_i.compressed,
                      itype: in_type, cause: '0, tval: '0,
                      priv: uop_entry_i.priv, iaddr: start_q};
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      start_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      held_q  <= '0;
      rec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      count_q <= count_d;
      last_q  <= last_d;
      held_q  <= held_d;
      rec_q   <= rec_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o     = valid_q;
  assign iretire_o   = rec_q.iretire;
  assign ilastsize_o = rec_q.ilastsize;
  assign itype_o     = rec_q.itype;
  assign cause_o     = rec_q.cause;
  assign tval_o      = rec_q.tval;
  assign priv_o      = rec_q.priv;
  assign iaddr_o     = rec_q.iaddr;

endmodule

// File: tb/tb_fsm.sv
// Directed bench for fsm: two instances (wide and 3-bit counters) checked every cycle against a record-FIFO model.
module tb_fsm;
  import mure_pkg::*;

  typedef struct packed {
    logic [14:0] iret;
    logic        last;
    logic [2:0]  itype;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [1:0]  priv;
    logic [31:0] iaddr;
  } rec_t;

  logic clk, rst_n, run;
  uop_entry_s uop;

  logic va, vb, la, lb;
  logic [14:0] ira;
  logic [2:0]  irb, ita, itb;
  logic [4:0]  ca, cb;
  logic [31:0] ta, tb, aa, ab;
  logic [1:0]  pa, pb;

  fsm #(.IRETIRE_LEN(15)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .uop_entry_i(uop), .valid_o(va), .iretire_o(ira),
    .ilastsize_o(la), .itype_o(ita), .cause_o(ca), .tval_o(ta), .priv_o(pa), .iaddr_o(aa));

  fsm #(.IRETIRE_LEN(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .uop_entry_i(uop), .valid_o(vb), .iretire_o(irb),
    .ilastsize_o(lb), .itype_o(itb), .cause_o(cb), .tval_o(tb), .priv_o(pb), .iaddr_o(ab));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: per instance, an open block (start, halfword count, last size) and a FIFO of
  // block records still to be presented; one record leaves the FIFO per clock.
  bit          open_m[2];
  int          cnt_m[2];
  logic [31:0] start_m[2];
  logic        last_m[2];
  rec_t        q0[$];
  rec_t        q1[$];
  rec_t        out_m[2];
  logic        vld_m[2];
  int          maxc[2] = '{32767, 7};

  function automatic rec_t mkrec(int n, logic l, logic [2:0] it, logic [4:0] c,
                                 logic [31:0] tv, logic [1:0] p, logic [31:0] a);
    rec_t r;
    r.iret = 15'(n); r.last = l; r.itype = it; r.cause = c; r.tval = tv; r.priv = p; r.iaddr = a;
    return r;
  endfunction

  task automatic push(int d, rec_t r);
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      open_m[d] = 0; cnt_m[d] = 0; start_m[d] = '0; last_m[d] = 1'b0;
      out_m[d] = '0; vld_m[d] = 1'b0;
    end
  endtask

  task automatic model_step(uop_entry_s u);
    logic [2:0] t;
    int sz;
    t  = (u.itype == 3'd7) ? 3'd0 : u.itype;
    sz = u.compressed ? 1 : 2;
    for (int d = 0; d < 2; d++) begin
      if (u.valid) begin
        if (t == 3'd1 || t == 3'd2) begin
          if (open_m[d]) push(d, mkrec(cnt_m[d], last_m[d], t, u.cause, u.tval, u.priv, start_m[d]));
          else           push(d, mkrec(0, 1'b0, t, u.cause, u.tval, u.priv, u.pc));
          open_m[d] = 0;
        end else begin
          if (open_m[d] && cnt_m[d] + sz > maxc[d]) begin
            push(d, mkrec(cnt_m[d], last_m[d], 3'd0, 5'd0, 32'd0, u.priv, start_m[d]));
            open_m[d] = 0;
          end
          if (!open_m[d]) begin
            if (t == 3'd0) begin
              open_m[d] = 1; start_m[d] = u.pc; cnt_m[d] = sz; last_m[d] = ~u.compressed;
            end else begin
              push(d, mkrec(sz, ~u.compressed, t, 5'd0, 32'd0, u.priv, u.pc));
            end
          end else begin
            cnt_m[d] += sz;
            last_m[d] = ~u.compressed;
            if (t != 3'd0) begin
              push(d, mkrec(cnt_m[d], last_m[d], t, 5'd0, 32'd0, u.priv, start_m[d]));
              open_m[d] = 0;
            end
          end
        end
      end
      if (d == 0 && q0.size() > 0)      begin out_m[0] = q0.pop_front(); vld_m[0] = 1'b1; end
      else if (d == 1 && q1.size() > 0) begin out_m[1] = q1.pop_front(); vld_m[1] = 1'b1; end
      else vld_m[d] = 1'b0;
    end
  endtask

  function automatic rec_t dut_rec(int d);
    if (d == 0) return mkrec(int'(ira), la, ita, ca, ta, pa, aa);
    return mkrec(int'(irb), lb, itb, cb, tb, pb, ab);
  endfunction

  function automatic logic dut_vld(int d);
    return (d == 0) ? va : vb;
  endfunction

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", name, d, cyc, act, exp);
    end
  endtask

  task automatic cmp_rec(string tag, int d, logic v, rec_t e);
    rec_t a;
    a = dut_rec(d);
    check({tag, ".valid"},   d, 32'(dut_vld(d)), 32'(v));
    check({tag, ".iretire"}, d, 32'(a.iret),  32'(e.iret));
    check({tag, ".ilast"},   d, 32'(a.last),  32'(e.last));
    check({tag, ".itype"},   d, 32'(a.itype), 32'(e.itype));
    check({tag, ".cause"},   d, 32'(a.cause), 32'(e.cause));
    check({tag, ".tval"},    d, a.tval,       e.tval);
    check({tag, ".priv"},    d, 32'(a.priv),  32'(e.priv));
    check({tag, ".iaddr"},   d, a.iaddr,      e.iaddr);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (run) begin
      for (int d = 0; d < 2; d++) cmp_rec("model", d, vld_m[d], out_m[d]);
    end
  end

  // Hand-computed pins of a pulse, independent of the model.
  task automatic expect_pulse(int d, int n, logic [31:0] a, logic [2:0] it, logic l,
                              logic [4:0] c = 0, logic [31:0] tv = 0, logic [1:0] p = 0);
    cmp_rec("pin", d, 1'b1, mkrec(n, l, it, c, tv, p, a));
  endtask

  function automatic uop_entry_s mk(logic [31:0] pc, logic [2:0] it, logic c,
                                    logic [4:0] cause = 0, logic [31:0] tval = 0,
                                    logic [1:0] priv = 0);
    uop_entry_s u;
    u.valid = 1'b1; u.pc = pc; u.itype = it; u.compressed = c;
    u.cause = cause; u.tval = tval; u.priv = priv;
    return u;
  endfunction

  task automatic step(uop_entry_s u);
    uop = u;
    @(posedge clk);
    model_step(u);
    @(negedge clk);
  endtask

  task automatic idle();
    step('0);
  endtask

  initial begin
    run   = 1'b0;
    rst_n = 1'b1;
    uop   = '0;
    #3 rst_n = 1'b0;
    model_reset();
    run = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) cmp_rec("reset", d, 1'b0, '0);

    step(mk(32'h100, 3'd0, 1'b0));
    step(mk(32'h104, 3'd0, 1'b0));
    step(mk(32'h108, 3'd5, 1'b0));
    for (int d = 0; d < 2; d++) expect_pulse(d, 6, 32'h100, 3'd5, 1'b1);
    idle();

    step(mk(32'h200, 3'd0, 1'b1));
    step(mk(32'h202, 3'd1, 1'b0, 5'd2, 32'hDEAD, 2'd3));
    for (int d = 0; d < 2; d++) expect_pulse(d, 1, 32'h200, 3'd1, 1'b0, 5'd2, 32'hDEAD, 2'd3);

    step(mk(32'h300, 3'd2, 1'b0, 5'd7));
    for (int d = 0; d < 2; d++) expect_pulse(d, 0, 32'h300, 3'd2, 1'b0, 5'd7);

    step(mk(32'h400, 3'd5, 1'b0));
    for (int d = 0; d < 2; d++) expect_pulse(d, 2, 32'h400, 3'd5, 1'b1);
    step(mk(32'h500, 3'd6, 1'b1));
    for (int d = 0; d < 2; d++) expect_pulse(d, 1, 32'h500, 3'd6, 1'b0);
    idle();

    step(mk(32'h0, 3'd0, 1'b0));
    step(mk(32'h4, 3'd0, 1'b0));
    step(mk(32'h8, 3'd0, 1'b0));
    step(mk(32'hC, 3'd0, 1'b0));
    expect_pulse(1, 6, 32'h0, 3'd0, 1'b1);
    step(mk(32'h10, 3'd5, 1'b0));
    expect_pulse(0, 10, 32'h0, 3'd5, 1'b1);
    expect_pulse(1, 4, 32'hC, 3'd5, 1'b1);
    idle();

    // Saturating closer on the narrow instance, followed directly by another closer.
    step(mk(32'h20, 3'd0, 1'b0));
    step(mk(32'h24, 3'd0, 1'b0));
    step(mk(32'h28, 3'd0, 1'b0));
    step(mk(32'h2C, 3'd6, 1'b0, 5'd0, 32'd0, 2'd1));
    expect_pulse(0, 8, 32'h20, 3'd6, 1'b1, 5'd0, 32'd0, 2'd1);
    expect_pulse(1, 6, 32'h20, 3'd0, 1'b1, 5'd0, 32'd0, 2'd1);
    step(mk(32'h30, 3'd3, 1'b1));
    expect_pulse(0, 1, 32'h30, 3'd3, 1'b0);
    expect_pulse(1, 2, 32'h2C, 3'd6, 1'b1, 5'd0, 32'd0, 2'd1);
    idle();
    expect_pulse(1, 1, 32'h30, 3'd3, 1'b0);
    idle();

    step(mk(32'h600, 3'd7, 1'b1));
    step(mk(32'h602, 3'd4, 1'b1));
    for (int d = 0; d < 2; d++) expect_pulse(d, 2, 32'h600, 3'd4, 1'b0);

    step(mk(32'h700, 3'd0, 1'b0));
    idle();
    idle();
    step(mk(32'h704, 3'd5, 1'b1));
    for (int d = 0; d < 2; d++) expect_pulse(d, 3, 32'h700, 3'd5, 1'b0);

    step(mk(32'h800, 3'd0, 1'b0));
    step(mk(32'h804, 3'd0, 1'b0));
    uop = '0;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) cmp_rec("midreset", d, 1'b0, '0);
    idle();
    idle();
    step(mk(32'h900, 3'd5, 1'b0));
    for (int d = 0; d < 2; d++) expect_pulse(d, 2, 32'h900, 3'd5, 1'b1);
    idle();
    idle();

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
